// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and default widths for the SRAM load/readback engine.
//   bank_e      - target bank encoding carried on cmd_sel
//   state_e     - engine state encoding
//   bank_onehot - bank to one-hot chip-select mapping
package mem_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned LEN_W_DEF  = 15;
  localparam int unsigned NUM_BANKS  = 3;

  typedef enum logic [1:0] {
    BANK_IM      = 2'd0,
    BANK_WM      = 2'd1,
    BANK_DM      = 2'd2,
    BANK_ILLEGAL = 2'd3
  } bank_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Chip-select pattern for a bank; the illegal code selects nothing.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input bank_e b);
    case (b)
      BANK_IM: return 3'b001;
      BANK_WM: return 3'b010;
      BANK_DM: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_loader_fifo2.sv
// mem_loader_fifo2: 2-entry registered FIFO with valid/ready on both sides.
//   in_valid/in_ready/in_data    - push side
//   out_valid/out_ready/out_data - pop side, out_data driven straight from storage
//   count                        - current occupancy (0..2)
module mem_loader_fifo2 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rptr_q];
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) begin
      mem_d[wptr_q] = in_data;
      wptr_d        = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: host-side load/readback engine for the IM/WM/DM SRAM banks.
//   cmd_*            - command: bank, base address, word count, direction
//   in_*             - write-data stream into the selected bank
//   out_*            - read-data stream out of the selected bank
//   done / err       - single-cycle completion / illegal-command pulses
//   sram_cs/oe/web/a/di - shared SRAM pins; sram_do_* return read data
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [1:0]             cmd_sel,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   done,
  output logic                   err,
  output logic [NUM_BANKS-1:0]   sram_cs,
  output logic                   sram_oe,
  output logic [DATA_W/8-1:0]    sram_web,
  output logic [ADDR_W-1:0]      sram_a,
  output logic [DATA_W-1:0]      sram_di,
  input  logic [DATA_W-1:0]      sram_do_im,
  input  logic [DATA_W-1:0]      sram_do_wm,
  input  logic [DATA_W-1:0]      sram_do_dm
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  bank_e               bank_q, bank_d;
  logic                inflight_q, inflight_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                in_ready_q, in_ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   a_hold_q, a_hold_d;
  logic [DATA_W-1:0]   di_hold_q, di_hold_d;

  logic                cmd_fire;
  logic                wr_fire;
  logic                rd_issue;
  logic                access;
  logic                zero_len;
  logic                fifo_in_ready;
  logic                fifo_pop;
  logic [1:0]          fifo_count;
  logic [2:0]          rd_pending;
  logic [DATA_W-1:0]   rd_data;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign wr_fire  = in_ready_q && in_valid;
  assign fifo_pop = out_valid && out_ready;

  // Words issued but not yet consumed once this cycle's pop is counted;
  // keeping this below 2 guarantees the FIFO always has room for DO.
  assign rd_pending = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
  assign rd_issue   = (state_q == ST_READ) && (rem_q != '0) &&
                      (rd_pending < 3'd2) && fifo_in_ready;
  assign access     = wr_fire || rd_issue;

  // Read data is valid the cycle after the access edge; mux by latched bank.
  always_comb begin
    case (bank_q)
      BANK_WM: rd_data = sram_do_wm;
      BANK_DM: rd_data = sram_do_dm;
      default: rd_data = sram_do_im;
    endcase
  end

  mem_loader_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_ready  (fifo_in_ready),
    .in_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (fifo_count)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    bank_d   = bank_q;
    err_d    = 1'b0;
    zero_len = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (bank_e'(cmd_sel) == BANK_ILLEGAL) begin
            err_d = 1'b1;
          end else if (cmd_len == '0) begin
            zero_len = 1'b1;
          end else begin
            state_d = cmd_write ? ST_WRITE : ST_READ;
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            bank_d  = bank_e'(cmd_sel);
          end
        end
      end
      ST_WRITE: begin
        if (wr_fire) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_READ: begin
        if (rd_issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave on the edge that empties the FIFO so done follows the last pop.
        if (!inflight_q &&
            ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && fifo_pop))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inflight_d  = rd_issue;
    cmd_ready_d = (state_d == ST_IDLE);
    in_ready_d  = (state_d == ST_WRITE);
    done_d      = (state_d == ST_DONE) || zero_len;
    a_hold_d    = access ? addr_q : a_hold_q;
    di_hold_d   = wr_fire ? in_data : di_hold_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      bank_q      <= BANK_IM;
      inflight_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      a_hold_q    <= '0;
      di_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      bank_q      <= bank_d;
      inflight_q  <= inflight_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      a_hold_q    <= a_hold_d;
      di_hold_q   <= di_hold_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign in_ready  = in_ready_q;
  assign done      = done_q;
  assign err       = err_q;

  // SRAM pins follow the handshake in the same cycle; bus holds between accesses.
  assign sram_cs  = access ? bank_onehot(bank_q) : '0;
  assign sram_oe  = rd_issue;
  assign sram_web = wr_fire ? {BE_W{1'b0}} : {BE_W{1'b1}};
  assign sram_a   = access ? addr_q : a_hold_q;
  assign sram_di  = wr_fire ? in_data : di_hold_q;

endmodule
